alu_arbiter: RTL

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : alu_arbiter
// Description : Two-requester arbiter that sequences one operation at a time
//               through an external combinational ALU and Shifter, then
//               presents the captured result on a response handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_arbiter #(
  parameter int RR_EN = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid_i,
  input  logic        req1_valid_i,
  output logic        req0_ready_o,
  output logic        req1_ready_o,
  input  logic [2:0]  req0_op_i,
  input  logic [2:0]  req1_op_i,
  input  logic [31:0] req0_a_i,
  input  logic [31:0] req0_b_i,
  input  logic [31:0] req1_a_i,
  input  logic [31:0] req1_b_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic        rsp_id_o,
  output logic [31:0] rsp_result_o,
  output logic        rsp_zero_o,
  output logic        rsp_overflow_o,
  output logic        busy_o,
  output logic [31:0] alu_src1_o,
  output logic [31:0] alu_src2_o,
  output logic        alu_invertA_o,
  output logic        alu_invertB_o,
  output logic [1:0]  alu_operation_o,
  input  logic [31:0] alu_result_i,
  input  logic        alu_zero_i,
  input  logic        alu_overflow_i,
  output logic        sft_leftRight_o,
  output logic [4:0]  sft_shamt_o,
  output logic [31:0] sft_src_o,
  input  logic [31:0] sft_result_i
);

  localparam logic [2:0] OP_AND = 3'd0;
  localparam logic [2:0] OP_OR  = 3'd1;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_SUB = 3'd3;
  localparam logic [2:0] OP_NOR = 3'd4;
  localparam logic [2:0] OP_SLT = 3'd5;
  localparam logic [2:0] OP_SLL = 3'd6;
  localparam logic [2:0] OP_SRL = 3'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        prio_q, prio_d;      // 0: requester 0 holds priority
  logic [2:0]  op_q;
  logic [31:0] a_q, b_q;
  logic        id_q;
  logic [31:0] res_q, res_d;
  logic        zero_q, zero_d;
  logic        ovf_q, ovf_d;
  logic        rid_q;
  logic        grant0, grant1, accept;
  logic        is_shift, is_arith;

  assign is_shift = (op_q == OP_SLL) || (op_q == OP_SRL);
  assign is_arith = (op_q == OP_ADD) || (op_q == OP_SUB);
  assign accept   = grant0 | grant1;

  // Grant only in IDLE and never while reset is asserted; ties go to prio_q.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if ((state_q == IDLE) && rst_n) begin
      if (req0_valid_i && (!req1_valid_i || !prio_q)) grant0 = 1'b1;
      else if (req1_valid_i)                          grant1 = 1'b1;
    end
  end

  assign req0_ready_o = grant0;
  assign req1_ready_o = grant1;

  // Next-state logic and round-robin pointer update.
  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    case (state_q)
      IDLE:    if (accept) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (rsp_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Priority passes to whichever requester was not just served.
    if ((RR_EN != 0) && accept) prio_d = grant0;
  end

  // Drive the external units from the registered request during EXEC only.
  always_comb begin
    alu_src1_o      = '0;
    alu_src2_o      = '0;
    alu_invertA_o   = 1'b0;
    alu_invertB_o   = 1'b0;
    alu_operation_o = 2'b00;
    sft_leftRight_o = 1'b0;
    sft_shamt_o     = '0;
    sft_src_o       = '0;
    if (state_q == EXEC) begin
      if (is_shift) begin
        sft_src_o       = a_q;
        sft_shamt_o     = b_q[4:0];
        sft_leftRight_o = (op_q == OP_SLL);
      end else begin
        alu_src1_o = a_q;
        alu_src2_o = b_q;
        case (op_q)
          OP_AND:  alu_operation_o = 2'b00;
          OP_OR:   alu_operation_o = 2'b01;
          OP_ADD:  alu_operation_o = 2'b10;
          OP_SUB:  begin alu_invertB_o = 1'b1; alu_operation_o = 2'b10; end
          OP_NOR:  begin alu_invertA_o = 1'b1; alu_invertB_o = 1'b1; end
          OP_SLT:  begin alu_invertB_o = 1'b1; alu_operation_o = 2'b11; end
          default: alu_operation_o = 2'b00;
        endcase
      end
    end
  end

  // Select what gets captured as the response at the end of EXEC.
  always_comb begin
    res_d  = res_q;
    zero_d = zero_q;
    ovf_d  = ovf_q;
    if (state_q == EXEC) begin
      res_d  = is_shift ? sft_result_i : alu_result_i;
      zero_d = is_shift ? (sft_result_i == 32'd0) : alu_zero_i;
      ovf_d  = is_arith & alu_overflow_i;
    end
  end

  // State, request fields and response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      prio_q  <= 1'b0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      id_q    <= 1'b0;
      res_q   <= '0;
      zero_q  <= 1'b0;
      ovf_q   <= 1'b0;
      rid_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      res_q   <= res_d;
      zero_q  <= zero_d;
      ovf_q   <= ovf_d;
      if (accept) begin
        op_q <= grant1 ? req1_op_i : req0_op_i;
        a_q  <= grant1 ? req1_a_i  : req0_a_i;
        b_q  <= grant1 ? req1_b_i  : req0_b_i;
        id_q <= grant1;
      end
      if (state_q == EXEC) rid_q <= id_q;
    end
  end

  assign rsp_valid_o    = (state_q == RESP);
  assign busy_o         = (state_q != IDLE);
  assign rsp_id_o       = rid_q;
  assign rsp_result_o   = res_q;
  assign rsp_zero_o     = zero_q;
  assign rsp_overflow_o = ovf_q;

endmodule
`default_nettype wire
